// File: rtl/avalon_mem_pkg.sv
// Shared constants and types for the Avalon-MM data memory.
// Holds the out-of-range read pattern and the response-pipeline entry type.
package avalon_mem_pkg;

  localparam logic [31:0] DEAD_PATTERN = 32'hDEAD_BEEF;
  localparam int MAX_READ_LATENCY = 4;

  typedef struct packed {
    logic        valid;
    logic        oor;
    logic [31:0] data;
  } rsp_t;

endpackage

// File: rtl/data_ram_bank.sv
// Word storage: one synchronous read port, one byte-enabled write port.
// Ports: clk, i_rd_en/i_rd_addr/o_rd_data, i_wr_en/i_wr_addr/i_wr_data/i_wr_be.
module data_ram_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic [3:0]    i_wr_be
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rd_data;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wr_be[i]) begin
          r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
        end
      end
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/avalon_data_mem.sv
// Avalon-MM slave data memory with fixed wait states and pipelined reads.
// Ports: clk, rst_n, avs_* slave bus, sticky err flag.
module avalon_data_mem
  import avalon_mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_CYCLES  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(DEPTH_WORDS):0] avs_address,
  input  logic                         avs_read,
  input  logic                         avs_write,
  input  logic [31:0]                  avs_writedata,
  input  logic [3:0]                   avs_byteenable,
  output logic                         avs_waitrequest,
  output logic [31:0]                  avs_readdata,
  output logic                         avs_readdatavalid,
  output logic                         err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] LP_WAIT = 2'(WAIT_CYCLES);

  if (DEPTH_WORDS < 16 || DEPTH_WORDS > 65536 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of two in 16..65536");
  end
  if (READ_LATENCY < 1 ||
      READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
    $error("READ_LATENCY must be in 1..4");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 3) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..3");
  end

  logic [1:0]  r_wcnt;
  logic        r_err;
  logic        r_head_v;
  logic        r_head_oor;
  logic        w_cmd;
  logic        w_accept;
  logic        w_oor;
  logic        w_both;
  logic        w_wr_en;
  logic        w_rd_acc;
  logic        w_rd_en;
  logic [31:0] w_ram_rdata;
  rsp_t        w_head;
  rsp_t        w_tail;

  assign w_cmd    = avs_read | avs_write;
  assign avs_waitrequest = w_cmd && (r_wcnt != LP_WAIT);
  assign w_accept = w_cmd && !avs_waitrequest;
  assign w_oor    = avs_address[AW];
  assign w_both   = avs_read && avs_write;
  assign w_wr_en  = w_accept && avs_write && !w_oor;
  // Read+write together is treated as a write only.
  assign w_rd_acc = w_accept && avs_read && !avs_write;
  assign w_rd_en  = w_rd_acc && !w_oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if (!w_cmd || w_accept) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && (w_oor || w_both)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  data_ram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk       (clk),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (avs_address[AW-1:0]),
    .o_rd_data (w_ram_rdata),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (avs_address[AW-1:0]),
    .i_wr_data (avs_writedata),
    .i_wr_be   (avs_byteenable)
  );

  // First stage lines up with the RAM's registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_v   <= 1'b0;
      r_head_oor <= 1'b0;
    end else begin
      r_head_v   <= w_rd_acc;
      r_head_oor <= w_oor;
    end
  end

  always_comb begin
    w_head       = '0;
    w_head.valid = r_head_v;
    w_head.oor   = r_head_oor;
    w_head.data  = w_ram_rdata;
  end

  if (READ_LATENCY == 1) begin : g_nopipe
    assign w_tail = w_head;
  end else begin : g_pipe
    rsp_t r_pipe [READ_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
          r_pipe[i] <= '0;
        end
      end else begin
        r_pipe[0] <= w_head;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign w_tail = r_pipe[READ_LATENCY-2];
  end

  assign avs_readdatavalid = w_tail.valid;
  assign avs_readdata =
    !w_tail.valid ? 32'h0 :
    w_tail.oor    ? DEAD_PATTERN : w_tail.data;

endmodule

// File: tb/tb_avalon_data_mem.sv
// Scoreboard bench for avalon_data_mem: zero-wait and two-wait instances.
// Stimulus pushes expected responses; monitors pop and compare on readdatavalid.
module tb_avalon_data_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] addr;
  logic        rd, wr;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        wreq, rvalid, err;
  logic [31:0] rdata;

  logic [10:0] w_addr;
  logic        w_rd, w_wr;
  logic [31:0] w_wd;
  logic        w_wreq, w_rvalid, w_err;
  logic [31:0] w_rdata;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] q_d[$];
  int          q_c[$];
  logic [31:0] qw_d[$];
  int          qw_c[$];
  logic [31:0] md, mwd;
  int          mc, mwc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_data_mem dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .avs_address       (addr),
    .avs_read          (rd),
    .avs_write         (wr),
    .avs_writedata     (wd),
    .avs_byteenable    (be),
    .avs_waitrequest   (wreq),
    .avs_readdata      (rdata),
    .avs_readdatavalid (rvalid),
    .err               (err)
  );

  avalon_data_mem #(.WAIT_CYCLES(2)) dut_w (
    .clk               (clk),
    .rst_n             (rst_n),
    .avs_address       (w_addr),
    .avs_read          (w_rd),
    .avs_write         (w_wr),
    .avs_writedata     (w_wd),
    .avs_byteenable    (4'hF),
    .avs_waitrequest   (w_wreq),
    .avs_readdata      (w_rdata),
    .avs_readdatavalid (w_rvalid),
    .err               (w_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (q_d.size() == 0) begin
          chk("spurious_rvalid", {31'b0, rvalid}, 32'h0);
        end else begin
          md = q_d.pop_front();
          mc = q_c.pop_front();
          chk("rdata", rdata, md);
          chk("rlat_cycle", cyc, mc);
        end
      end else begin
        chk("idle_rdata", rdata, 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_rvalid) begin
      if (qw_d.size() == 0) begin
        chk("w_spurious_rvalid", {31'b0, w_rvalid}, 32'h0);
      end else begin
        mwd = qw_d.pop_front();
        mwc = qw_c.pop_front();
        chk("w_rdata", w_rdata, mwd);
        chk("w_rlat_cycle", cyc, mwc);
      end
    end
  end

  task automatic cmd(input logic r, input logic w,
                     input logic [10:0] a,
                     input logic [31:0] d,
                     input logic [3:0] b,
                     input logic exp_rsp,
                     input logic [31:0] exp_d);
    @(negedge clk);
    rd = r; wr = w; addr = a; wd = d; be = b;
    #1;
    chk("waitreq0", {31'b0, wreq}, 32'h0);
    if (exp_rsp) begin
      q_d.push_back(exp_d);
      q_c.push_back(cyc + 2);
    end
    @(posedge clk);
  endtask

  task automatic wr_t(input logic [10:0] a,
                      input logic [31:0] d,
                      input logic [3:0] b);
    cmd(1'b0, 1'b1, a, d, b, 1'b0, 32'h0);
  endtask

  task automatic rd_t(input logic [10:0] a,
                      input logic [31:0] e);
    cmd(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, e);
  endtask

  task automatic idle();
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic chk_err(input string nm, input logic e);
    @(negedge clk);
    #1;
    chk(nm, {31'b0, err}, {31'b0, e});
  endtask

  task automatic do_rst();
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Holds one command on the two-wait instance: 1,1,0 waitrequest.
  task automatic wcmd(input logic r, input logic w,
                      input logic [10:0] a,
                      input logic [31:0] d,
                      input logic [31:0] exp_d);
    @(negedge clk);
    w_rd = r; w_wr = w; w_addr = a; w_wd = d;
    #1;
    chk("wait_c1", {31'b0, w_wreq}, 32'h1);
    @(negedge clk);
    #1;
    chk("wait_c2", {31'b0, w_wreq}, 32'h1);
    @(negedge clk);
    #1;
    chk("wait_c3", {31'b0, w_wreq}, 32'h0);
    if (r) begin
      qw_d.push_back(exp_d);
      qw_c.push_back(cyc + 2);
    end
    @(negedge clk);
    w_rd = 1'b0; w_wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; be = '0;
    w_rd = 1'b0; w_wr = 1'b0; w_addr = '0; w_wd = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_waitreq", {31'b0, wreq}, 32'h0);

    wr_t(11'h010, 32'h1234_5678, 4'hF);
    rd_t(11'h010, 32'h1234_5678);
    wr_t(11'h005, 32'hFFFF_FFFF, 4'hF);
    wr_t(11'h005, 32'h0000_00AB, 4'h1);
    rd_t(11'h005, 32'hFFFF_FFAB);
    wr_t(11'h006, 32'hA5A5_A5A5, 4'hF);
    wr_t(11'h006, 32'h0000_0000, 4'h0);
    rd_t(11'h006, 32'hA5A5_A5A5);
    wr_t(11'h007, 32'h1122_3344, 4'hF);
    wr_t(11'h007, 32'hAABB_CCDD, 4'hA);
    rd_t(11'h007, 32'hAA22_CC44);
    for (int i = 1; i <= 4; i++) begin
      wr_t(11'(i), 32'h100 + i, 4'hF);
    end
    for (int i = 1; i <= 4; i++) begin
      rd_t(11'(i), 32'h100 + i);
    end
    wr_t(11'h3FF, 32'hCAFE_F00D, 4'hF);
    rd_t(11'h3FF, 32'hCAFE_F00D);
    idle();
    chk_err("err_clean", 1'b0);

    wr_t(11'h405, 32'h0, 4'hF);
    idle();
    chk_err("err_oor_wr", 1'b1);
    rd_t(11'h005, 32'hFFFF_FFAB);
    idle();
    repeat (4) @(negedge clk);

    do_rst();
    rd_t(11'h400, 32'hDEAD_BEEF);
    idle();
    chk_err("err_oor_rd", 1'b1);
    repeat (4) @(negedge clk);

    do_rst();
    cmd(1'b1, 1'b1, 11'h008, 32'h8765_4321, 4'hF, 1'b0, 32'h0);
    idle();
    repeat (4) @(negedge clk);
    chk_err("err_rw", 1'b1);
    rd_t(11'h008, 32'h8765_4321);
    idle();

    wcmd(1'b0, 1'b1, 11'h003, 32'h5A5A_1234, 32'h0);
    wcmd(1'b1, 1'b0, 11'h003, 32'h0, 32'h5A5A_1234);

    for (int i = 0; i < 20 && (q_d.size() + qw_d.size()) != 0; i++)
      @(negedge clk);
    repeat (2) @(negedge clk);

    cmd(1'b1, 1'b0, 11'h005, 32'h0, 4'h0, 1'b0, 32'h0);
    @(negedge clk);
    rd = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("inflight_rvalid", {31'b0, rvalid}, 32'h0);
    chk("inflight_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk_err("err_after_rst", 1'b0);
    rd_t(11'h001, 32'h0000_0101);
    idle();

    for (int i = 0; i < 20 && (q_d.size() + qw_d.size()) != 0; i++)
      @(negedge clk);
    chk("drain", q_d.size() + qw_d.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/avalon_data_mem.md
AVALON_DATA_MEM -- requirements
Module: avalon_data_mem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored (power of two, 16..65536).
REQ-002 The block SHALL have parameter READ_LATENCY, default 2, meaning the cycles from read acceptance to readdatavalid (legal 1..4).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 0, meaning the fixed wait states inserted per command (legal 0..3).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port avs_address, input, log2(DEPTH_WORDS)+1 bits: the word address, where the MSB set means out of range.
REQ-007 The block SHALL have ports avs_read and avs_write, each input, 1 bit: the command strobes, held until accepted.
REQ-008 The block SHALL have port avs_writedata, input, 32 bits: the write data.
REQ-009 The block SHALL have port avs_byteenable, input, 4 bits: the byte lane enables, where bit i enables bits 8i+7:8i.
REQ-010 The block SHALL have port avs_waitrequest, output, 1 bit: the command-not-accepted indication.
REQ-011 The block SHALL have port avs_readdata, output, 32 bits: the read response data.
REQ-012 The block SHALL have port avs_readdatavalid, output, 1 bit: the read response strobe, high for 1 cycle per response.
REQ-013 The block SHALL have port err, output, 1 bit: a sticky flag set on a protocol or range error.

Function
REQ-014 A command SHALL be accepted in the cycle where (avs_read|avs_write)=1 and avs_waitrequest=0.
REQ-015 avs_waitrequest SHALL equal (avs_read|avs_write) && (wcnt != WAIT_CYCLES), combinationally.
REQ-016 wcnt SHALL be 2 bits, increment while a command is presented and not accepted, and clear to 0 on acceptance or when no command is presented.
REQ-017 With WAIT_CYCLES=N, each command SHALL see N cycles of waitrequest=1 and then be accepted on cycle N+1.
REQ-018 An accepted write SHALL update only the enabled byte lanes at the accept edge; byteenable=0000 SHALL be a legal no-op.
REQ-019 An accepted read SHALL present avs_readdata with avs_readdatavalid=1 exactly READ_LATENCY cycles after the accept cycle.
REQ-020 Reads SHALL be fully pipelined: one acceptance per cycle, up to READ_LATENCY in flight, responses in order.
REQ-021 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-022 When avs_readdatavalid=0, avs_readdata SHALL be 32'h0.
REQ-023 An out-of-range read SHALL return 32'hDEAD_BEEF at normal latency and set err.
REQ-024 An out-of-range write SHALL be accepted, leave memory unchanged, and set err.
REQ-025 avs_read=avs_write=1 in the same cycle SHALL be accepted as a write only, with no read response, and SHALL set err.
REQ-026 err SHALL remain set until reset.
REQ-027 Address bits beyond log2(DEPTH_WORDS) inside range SHALL NOT exist; no wrap-around aliasing SHALL occur.

Reset
REQ-028 While rst_n=0, the block SHALL hold avs_readdatavalid=0, avs_readdata=0, err=0, wcnt=0, and clear the read-latency pipeline.
REQ-029 Reads in flight when reset asserts SHALL be discarded and never produce a response.
REQ-030 Memory contents SHALL NOT be reset and SHALL be undefined until written.
REQ-031 Deassertion of rst_n SHALL allow command acceptance on the first following rising edge.

Structure
REQ-032 Package avalon_mem_pkg SHALL hold the constant DEAD_PATTERN=32'hDEAD_BEEF, the constant MAX_READ_LATENCY=4, and the response-pipeline entry typedef {valid, oor, data}.
REQ-033 Storage SHALL be the sub-module data_ram_bank: one read port and one byte-enabled write port, synchronous read with 1-cycle latency, with the remaining READ_LATENCY-1 stages in avalon_data_mem.
REQ-034 Parameter legality SHALL be checked by elaboration-time assertions.

Verification
REQ-035 With WAIT_CYCLES=0 and READ_LATENCY=2: write 0x0000_0010 <- 0x1234_5678 (be=1111), then read 0x10 -> readdatavalid at accept+2 with data 0x1234_5678.
REQ-036 Write addr 5 <- 0xFFFF_FFFF, then write addr 5 <- 0x0000_00AB with be=0001, then read addr 5 -> 0xFFFF_FFAB.
REQ-037 With WAIT_CYCLES=2, hold a read for 3 cycles -> waitrequest 1,1,0, and the response 2 cycles after the third cycle.
REQ-038 Back-to-back reads of addrs 1,2,3,4 on consecutive cycles -> 4 consecutive valid responses in order.
REQ-039 Read with address MSB set -> response 0xDEAD_BEEF and err=1; read=write=1 -> no response and err=1.
REQ-040 Assert rst_n=0 one cycle after a read is accepted -> no readdatavalid ever appears, and err=0.
